// File: rtl/mux16_rr_arbiter.sv
// ============================================================================
// Module   : mux16_rr_arbiter
// Brief    : Round-robin arbiter owning the 4-bit select of a shared 16:1 mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux16_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] gnt,
    output logic [3:0]  sel,
    output logic        busy,
    output logic        tmo
);

    localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_ptr, w_ptr_nxt;
    logic [7:0]  r_hcnt, w_hcnt_nxt;
    logic [3:0]  r_sel, w_sel_nxt;
    logic [15:0] r_gnt, w_gnt_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_tmo, w_tmo_nxt;

    logic [3:0]  w_cand;
    logic [3:0]  w_pick_idx;
    logic        w_pick_vld;
    logic        w_rel_wd;
    logic        w_rel_lim;

    // First requester at or above the pointer, wrapping past 15.
    always_comb begin
        w_cand     = r_ptr;
        w_pick_idx = r_ptr;
        w_pick_vld = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w_cand = r_ptr + 4'(i);
            if (!w_pick_vld && req[w_cand]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 4'd0;
            r_hcnt  <= 8'd0;
            r_sel   <= 4'd0;
            r_gnt   <= 16'd0;
            r_busy  <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt   <= w_gnt_nxt;
            r_busy  <= w_busy_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hcnt_nxt  = r_hcnt;
        w_sel_nxt   = r_sel;
        w_gnt_nxt   = r_gnt;
        w_busy_nxt  = r_busy;
        w_tmo_nxt   = 1'b0;
        w_rel_wd    = ~req[r_sel];
        w_rel_lim   = (r_hcnt == c_max_hold);

        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt  = 16'd0;
                w_busy_nxt = 1'b0;
                if (w_pick_vld) begin
                    w_sel_nxt   = w_pick_idx;
                    w_gnt_nxt   = 16'h0001 << w_pick_idx;
                    w_busy_nxt  = 1'b1;
                    w_hcnt_nxt  = 8'd1;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (done || w_rel_wd || w_rel_lim) begin
                    w_gnt_nxt   = 16'd0;
                    w_busy_nxt  = 1'b0;
                    w_ptr_nxt   = r_sel + 4'd1;
                    w_state_nxt = ST_IDLE;
                    // Timeout flagged only when nothing earlier in priority released.
                    w_tmo_nxt   = w_rel_lim && !done && !w_rel_wd;
                end else begin
                    w_hcnt_nxt = r_hcnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = r_busy;
    assign tmo  = r_tmo;

endmodule

`default_nettype wire

// File: tb/tb_mux16_rr_arbiter.sv
// ============================================================================
// Module   : tb_mux16_rr_arbiter
// Brief    : Self-checking bench for mux16_rr_arbiter against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux16_rr_arbiter;

    localparam int MAX_HOLD = 8;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        busy;
    logic        tmo;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner index (-1 when idle), priority start, hold length.
    int m_owner;
    int m_ptr;
    int m_hold;
    int m_sel;
    bit m_tmo;

    mux16_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .done (done),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy),
        .tmo  (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_sel   = 0;
        m_tmo   = 1'b0;
    endtask

    task automatic m_edge(input logic [15:0] r, input logic d);
        m_tmo = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < 16; k++) begin
                int j;
                j = (m_ptr + k) % 16;
                if (r[j]) begin
                    m_owner = j;
                    m_sel   = j;
                    m_hold  = 1;
                    break;
                end
            end
        end else if (d || !r[m_owner] || m_hold == MAX_HOLD) begin
            m_tmo   = !d && r[m_owner] && (m_hold == MAX_HOLD);
            m_ptr   = (m_owner + 1) % 16;
            m_owner = -1;
        end else begin
            m_hold++;
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] eg;
        eg = (m_owner >= 0) ? (16'h0001 << m_owner) : 16'h0000;
        chk_eq({tag, ".gnt"},  32'(gnt),  32'(eg));
        chk_eq({tag, ".sel"},  32'(sel),  32'(m_sel));
        chk_eq({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
        chk_eq({tag, ".tmo"},  32'(tmo),  32'(m_tmo));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!rst_n) m_reset();
        else        m_edge(req, done);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        req   = 16'h0000;
        done  = 1'b0;
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int rot[4];
        rot = '{0, 4, 15, 0};

        // Reset held with every requester asserting.
        rst_n = 1'b0;
        req   = 16'hFFFF;
        done  = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst.gnt",  32'(gnt),  32'h0);
        chk_eq("rst.sel",  32'(sel),  32'h0);
        chk_eq("rst.busy", 32'(busy), 32'h0);
        chk_eq("rst.tmo",  32'(tmo),  32'h0);
        rst_n = 1'b1;
        step("rst_rel");
        chk_eq("rst_first_gnt", 32'(gnt), 32'h0001);

        // Single requester finishing in its third grant cycle.
        do_reset();
        req = 16'h0008;
        step("single1");
        chk_eq("single_gnt", 32'(gnt), 32'h0008);
        step("single2");
        step("single3");
        done = 1'b1;
        step("single_rel");
        chk_eq("single_gap", 32'(gnt), 32'h0);
        done = 1'b0;
        step("single_regrant");
        chk_eq("single_regrant_sel", 32'(sel), 32'd3);

        // Rotation through three requesters with a gap between grants.
        do_reset();
        req = 16'h8011;
        for (int g = 0; g < 4; g++) begin
            step("rot_gnt");
            chk_eq("rot_sel", 32'(sel), 32'(rot[g]));
            done = 1'b1;
            step("rot_gap");
            chk_eq("rot_gap_busy", 32'(busy), 32'h0);
            done = 1'b0;
        end

        // Forced release after MAX_HOLD cycles.
        do_reset();
        req = 16'h0400;
        for (int c = 0; c < MAX_HOLD; c++) step("tmo_hold");
        chk_eq("tmo_hold_gnt", 32'(gnt), 32'h0400);
        step("tmo_rel");
        chk_eq("tmo_pulse", 32'(tmo), 32'h1);
        chk_eq("tmo_busy",  32'(busy), 32'h0);
        req = 16'hFFFF;
        step("tmo_ptr");
        chk_eq("tmo_ptr_gnt", 32'(gnt), 32'h0800);
        step("tmo_pulse_gone");
        chk_eq("tmo_once", 32'(tmo), 32'h0);

        // done on the same edge the hold limit is reached.
        for (int c = 0; c < MAX_HOLD - 2; c++) step("dlim_hold");
        done = 1'b1;
        step("dlim_rel");
        chk_eq("dlim_tmo",  32'(tmo),  32'h0);
        chk_eq("dlim_busy", 32'(busy), 32'h0);
        done = 1'b0;

        // Withdrawal of the granted request.
        step("wd_gnt");
        chk_eq("wd_sel", 32'(sel), 32'd12);
        step("wd_hold");
        req = 16'hEFFF;
        step("wd_rel");
        chk_eq("wd_busy", 32'(busy), 32'h0);
        chk_eq("wd_tmo",  32'(tmo),  32'h0);

        // Asynchronous reset in the middle of a grant.
        req = 16'hFFFF;
        step("ar_gnt");
        step("ar_hold");
        chk_eq("ar_pre_busy", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk_eq("ar_gnt",  32'(gnt),  32'h0);
        chk_eq("ar_busy", 32'(busy), 32'h0);
        chk_eq("ar_sel",  32'(sel),  32'h0);
        #1;
        rst_n = 1'b1;
        step("ar_after");
        chk_eq("ar_after_gnt", 32'(gnt), 32'h0001);

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       req = 16'h0000;
                    1:       req = 16'h0001 << $urandom_range(0, 15);
                    2:       req = 16'hFFFF;
                    default: req = 16'($urandom);
                endcase
            end
            done = ($urandom_range(0, 5) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux16_rr_arbiter.md
# mux16_rr_arbiter

Round-robin arbiter that shares one 16:1 multiplexer path among 16 requesters. It grants exactly one requester at a time and drives the mux select with that requester's index. It holds the grant until the requester signals completion or a hold limit expires. It sits in front of the 16:1 mux datapath and is the only driver of that mux's 4-bit select.

## Interface
- `MAX_HOLD`, default 8: maximum cycles a grant may be held before forced release; legal range 1..255.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  16  request vector; bit i = requester i wants the mux path.
- `done`  input  1  granted requester finishes its transaction (sampled only in GRANT).
- `gnt`  output  16  one-hot grant, or all zero.
- `sel`  output  4  mux select, equal to the index of the granted bit while `busy`=1.
- `busy`  output  1  high while a grant is active.
- `tmo`  output  1  one-cycle pulse when a grant is force-released by `MAX_HOLD`.

## Operation
- State registers: 2-state FSM (IDLE, GRANT), 4-bit priority pointer `ptr`, 8-bit hold counter `hcnt`, 4-bit `sel`.
- Reset (async, `rst_n`=0): state=IDLE, `gnt`=0, `sel`=0, `busy`=0, `tmo`=0, `ptr`=0, `hcnt`=0. Takes effect immediately, including mid-grant. First arbitration after release uses `ptr`=0.
- IDLE, `req`≠0 at an edge:
  - Select the first set bit scanning upward from index `ptr`, wrapping 15→0.
  - Load `sel`=index and `gnt`=1<<index, set `busy`=1 and `hcnt`=1, go to GRANT.
- IDLE, `req`=0: stay in IDLE. `gnt`=0 and `busy`=0. `sel` holds its last value and is not cleared.
- GRANT, release conditions evaluated at each edge, in priority order:
  1. `done`=1.
  2. `req[sel]`=0 (requester withdrew).
  3. `hcnt`=`MAX_HOLD`.
- GRANT, on release:
  - `gnt`=0, `busy`=0, `ptr`=(`sel`+1) mod 16, go to IDLE.
  - `tmo`=1 for one cycle only if condition 3 caused the release and conditions 1 and 2 were false.
- GRANT, no release: `hcnt` increments. `gnt`, `sel` and `busy` stay stable.
- `tmo` is 0 in every cycle other than the forced-release pulse.
- Changes to `req` bits other than `sel` have no effect during GRANT.
- Invariants:
  - `gnt` has at most one bit set.
  - `gnt`≠0 if and only if `busy`=1.
  - When `busy`=1, `gnt[sel]`=1.

## Timing
- All outputs are registered; none is combinational from inputs.
- Request-to-grant latency: `req` is sampled at edge t and `gnt`/`sel`/`busy` are valid after edge t. Latency is 1 cycle from request assertion.
- Maximum grant length is `MAX_HOLD` cycles. The grant is visible for cycles 1..`MAX_HOLD` and drops after the edge where `hcnt`=`MAX_HOLD`.
- Every release is followed by exactly one IDLE cycle with `gnt`=0. This is the mux settling gap.
- Back-to-back grants therefore start at most every `MAX_HOLD`+1 cycles.
- `done` asserted on the same edge the grant is issued is ignored, because `done` is sampled only in GRANT.
- Fairness: with all 16 requesters continuously asserting, each is granted exactly once per 16 grants, in order 0,1,…,15,0.

## Test plan
- Reset: hold `rst_n`=0 with `req`=16'hFFFF -> `gnt`=0, `sel`=0, `busy`=0, `tmo`=0. Release reset -> one cycle later `gnt`=16'h0001 and `sel`=0.
- Single requester with done: `req`=16'h0008, `done` pulsed in grant cycle 3 -> `gnt`=16'h0008 and `sel`=3 for 3 cycles, then one IDLE cycle, then regrant of 3 because it is the only requester. `tmo` never asserts.
- Rotation: `req`=16'h8011 held, `done` pulsed on every grant cycle 1 -> `sel` sequence 0,4,15,0 with a `gnt`=0 gap between each grant.
- Timeout: `MAX_HOLD`=8, `req`=16'h0400 held, `done`=0 -> `gnt`=16'h0400 for 8 cycles, then `tmo`=1 for one cycle, `busy`=0 and `ptr`=11.
- Done coinciding with timeout: `done`=1 on the edge where `hcnt`=8 -> release happens, `tmo` stays 0.
- Withdraw and reset mid-grant:
  - Deassert `req[sel]` during GRANT -> release on the next edge, `tmo`=0.
  - Separately, assert `rst_n`=0 mid-grant -> `gnt`, `busy` and `sel` clear immediately without waiting for a clock edge.
